// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
//   MEM pipeline stage. It talks to data memory through a req/ack handshake,
//   freezes the upstream pipeline while an access is outstanding, resolves
//   branches, and drives the MEM/WB pipeline register.
//
//   State table:
//     IDLE | no access outstanding; a memory op at the inputs launches one
//     REQ  | dmem_req held with stable addr/wdata/we until dmem_ack
//     DONE | read data captured; the op retires into MEM/WB this cycle
//
//   Optional feature macro: MEM_ALIGN_CHECK_EN
//     When defined, memory ops with result_in[2:0] != 0 issue no request,
//     retire with wb_reg_write=0, and flag misaligned for one MEM/WB cycle.
//     When undefined, addresses are issued as-is and misaligned is tied 0.
//
//   Ports:
//     clock, reset           rising-edge clock, synchronous active-high reset
//     adder_in ... reg_write_in  EX/MEM inputs (branch target, ALU result /
//                            address, store data, rd, control bits)
//     dmem_req/we/addr/wdata data-memory request (registered)
//     dmem_rdata, dmem_ack   data-memory response
//     pc_src, branch_target  branch taken and its target
//     flush_out              flush IF/ID, ID/EX, EX/MEM on a taken branch
//     stall                  freeze PC, IF/ID, ID/EX, EX/MEM
//     wb_*                   MEM/WB register outputs
//     misaligned             alignment fault flag (MEM/WB timing)
// -----------------------------------------------------------------------------
module mem_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic [63:0] adder_in,
    input  logic [63:0] result_in,
    input  logic [63:0] write_data_in,
    input  logic [4:0]  rd_in,
    input  logic        branch_in,
    input  logic        zero_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic        mem_to_reg_in,
    input  logic        reg_write_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [63:0] dmem_addr,
    output logic [63:0] dmem_wdata,
    input  logic [63:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        pc_src,
    output logic [63:0] branch_target,
    output logic        flush_out,
    output logic        stall,
    output logic [63:0] wb_read_data,
    output logic [63:0] wb_result,
    output logic [4:0]  wb_rd,
    output logic        wb_mem_to_reg,
    output logic        wb_reg_write,
    output logic        wb_valid,
    output logic        misaligned
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [63:0] rdata_cap;
    logic        mem_op;
    logic        misalign;
    logic        issue_op;

    assign mem_op = mem_read_in | mem_write_in;

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = mem_op & (result_in[2:0] != 3'b000);
`else
    assign misalign = 1'b0;
`endif

    // A misaligned op behaves like a non-memory op: no request, no stall.
    assign issue_op = mem_op & ~misalign;

    // In DONE the retiring op is still at the inputs; it must not stall
    // again or it would never leave the stage.
    assign stall         = ((state == IDLE) & issue_op) | (state == REQ);
    assign pc_src        = branch_in & zero_in & ~stall;
    assign flush_out     = pc_src;
    assign branch_target = adder_in;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 64'd0;
            dmem_wdata <= 64'd0;
            rdata_cap  <= 64'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue_op) begin
                        state      <= REQ;
                        dmem_req   <= 1'b1;
                        dmem_we    <= mem_write_in;
                        dmem_addr  <= result_in;
                        dmem_wdata <= write_data_in;
                    end
                end
                REQ: begin
                    if (dmem_ack) begin
                        state     <= DONE;
                        dmem_req  <= 1'b0;
                        dmem_we   <= 1'b0;
                        rdata_cap <= dmem_rdata;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    dmem_req <= 1'b0;
                    dmem_we  <= 1'b0;
                end
            endcase
        end
    end

    // MEM/WB register: bubble while stalled, otherwise the current op.
    always_ff @(posedge clock) begin
        if (reset || stall) begin
            wb_read_data  <= 64'd0;
            wb_result     <= 64'd0;
            wb_rd         <= 5'd0;
            wb_mem_to_reg <= 1'b0;
            wb_reg_write  <= 1'b0;
            wb_valid      <= 1'b0;
            misaligned    <= 1'b0;
        end else begin
            wb_read_data  <= (state == DONE) ? rdata_cap : 64'd0;
            wb_result     <= result_in;
            wb_rd         <= rd_in;
            wb_mem_to_reg <= mem_to_reg_in;
            wb_reg_write  <= reg_write_in & ~misalign;
            wb_valid      <= 1'b1;
            misaligned    <= misalign;
        end
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL use: clock  in  1  rising-edge clock; reset  in  1  reset, synchronous, active-high.
REQ-002 The block SHALL accept from EX/MEM: adder_in 64 (branch target), result_in 64 (ALU result / address), write_data_in 64, rd_in 5, and 1-bit branch_in, zero_in, mem_read_in, mem_write_in, mem_to_reg_in, reg_write_in.
REQ-003 The block SHALL drive the data-memory port: dmem_req out 1, dmem_we out 1, dmem_addr out 64, dmem_wdata out 64; and receive dmem_rdata in 64, dmem_ack in 1.
REQ-004 The block SHALL drive pc_src out 1 (take branch), branch_target out 64, flush_out out 1 (flush IF/ID, ID/EX, EX/MEM), and stall out 1 (freeze PC, IF/ID, ID/EX, EX/MEM).
REQ-005 The block SHALL drive MEM/WB outputs: wb_read_data 64, wb_result 64, wb_rd 5, wb_mem_to_reg 1, wb_reg_write 1, wb_valid 1, misaligned 1.

Function
REQ-006 A memory op SHALL be mem_read_in|mem_write_in; mem_write_in takes priority when both are set (dmem_we=1).
REQ-007 The FSM SHALL have states IDLE, REQ, DONE; reset state IDLE.
REQ-008 IDLE with memory op present SHALL transition to REQ, registering dmem_addr=result_in, dmem_wdata=write_data_in, dmem_we=mem_write_in.
REQ-009 REQ SHALL hold dmem_req=1 with addr/wdata/we stable until dmem_ack=1, then capture dmem_rdata and transition to DONE.
REQ-010 DONE SHALL transition unconditionally to IDLE; the op still at the inputs in DONE SHALL NOT re-trigger a request.
REQ-011 stall SHALL equal (IDLE & memory op) | REQ, combinationally; stall SHALL be 0 in DONE.
REQ-012 dmem_ack in IDLE or DONE SHALL be ignored.
REQ-013 The MEM/WB register SHALL update every clock: while stall=1 it loads a bubble (wb_valid=0, wb_reg_write=0, wb_mem_to_reg=0, wb_rd=0, data 0); otherwise it loads rd_in, result_in, mem_to_reg_in, reg_write_in, wb_valid=1, and wb_read_data=captured rdata (DONE) or 0.
REQ-014 Minimum memory-op latency SHALL be: op at inputs cycle N, dmem_req high cycle N+1, ack in N+1 gives DONE in N+2, MEM/WB valid from N+3; each extra ack-wait cycle adds one.
REQ-015 Non-memory ops SHALL pass to MEM/WB in one cycle with stall=0.
REQ-016 pc_src SHALL equal branch_in & zero_in & ~stall, combinationally; flush_out SHALL equal pc_src; branch_target SHALL equal adder_in.

Reset
REQ-017 Reset SHALL force state IDLE, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, captured rdata=0, all wb_* outputs 0, misaligned=0.
REQ-018 Reset asserted in REQ SHALL drop dmem_req at that same clock edge; an ack arriving afterward SHALL be ignored.

Configuration
REQ-019 With MEM_ALIGN_CHECK_EN defined, a memory op with result_in[2:0]!=0 SHALL issue no request, SHALL not stall, SHALL pass to MEM/WB with wb_reg_write=0, and SHALL set misaligned=1 for that one MEM/WB cycle.
REQ-020 Without MEM_ALIGN_CHECK_EN, no alignment check SHALL exist, every address SHALL be issued as-is, and misaligned SHALL be tied 0.

Verification
REQ-021 Load at 0x100, rd=5, ack in first REQ cycle with rdata=0xDEADBEEF -> stall high 2 cycles, dmem_req high 1 cycle, wb_read_data=0xDEADBEEF, wb_rd=5, wb_valid=1.
REQ-022 Store 0x1234 to 0x200, ack delayed 3 cycles -> dmem_we=1, addr/wdata stable 4 req cycles, stall held throughout, single request only.
REQ-023 branch_in=1, zero_in=1, adder_in=0x80 -> pc_src=1, flush_out=1, branch_target=0x80 same cycle; with zero_in=0 -> pc_src=0.
REQ-024 Reset asserted in REQ, then ack pulsed -> dmem_req=0 after the edge, state IDLE, no MEM/WB write.
REQ-025 Back-to-back ALU op, load, ALU op -> ALU ops each one cycle, load inserts bubbles with wb_valid=0 while stall=1, no op lost or duplicated.
REQ-026 With MEM_ALIGN_CHECK_EN, load at 0x103 -> no dmem_req, misaligned=1, wb_reg_write=0; without it, request issued with dmem_addr=0x103.
